// File: rtl/alu_driver_pkg.sv
// Shared types and constants for the ALU sequencing front end.
// Opcode encodings match the ALU's ALUControl input; flags are ordered {Z,O,N}.
package alu_pkg;

  localparam int ALU_W  = 19;
  localparam int FLAG_Z = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    OP_SUM  = 3'b000,
    OP_RES  = 3'b001,
    OP_MULT = 3'b010,
    OP_DIV  = 3'b011,
    OP_MOD  = 3'b100,
    OP_CLI  = 3'b101,
    OP_TRFI = 3'b110,
    OP_ALM  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } drv_state_t;

  // Ops that go through the combinational divider and need the long EXEC window.
  function automatic logic is_multicycle(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_driver_if.sv
// Bundle of decode-side handshake, ALU, writeback and store signals around alu_driver.
// master = the driver itself; slave = decode stage, ALU and memory around it.
interface alu_driver_if
  import alu_pkg::*;
#(
  parameter int N  = ALU_W,
  parameter int AW = 4
) ();

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_ra;
  logic [AW-1:0] in_rb;
  logic          in_imm_en;
  logic [N-1:0]  in_imm;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [2:0]    alu_ctrl;
  logic [N-1:0]  alu_result;
  logic [2:0]    alu_flags;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [N-1:0]  wb_data;
  logic [2:0]    flags_q;
  logic          mem_we;
  logic [N-1:0]  mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          busy;

  modport master (
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm_en, in_imm,
    input  alu_result, alu_flags,
    output in_ready, alu_a, alu_b, alu_ctrl,
    output wb_valid, wb_addr, wb_data, flags_q,
    output mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output in_valid, in_op, in_rd, in_ra, in_rb, in_imm_en, in_imm,
    output alu_result, alu_flags,
    input  in_ready, alu_a, alu_b, alu_ctrl,
    input  wb_valid, wb_addr, wb_data, flags_q,
    input  mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/alu_driver_reg_file.sv
// NREG x N register file: two asynchronous read ports, one synchronous write port.
// r0 always reads zero and ignores writes; all entries clear on reset.
module reg_file
  import alu_pkg::*;
#(
  parameter int N    = ALU_W,
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_a,
  output logic [N-1:0]  rdata_b
);

  logic [N-1:0] regs_r [NREG];

  // Storage: cleared on reset, written at the clock edge that ends WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {N{1'b0}};
      end
    end else if (we && (waddr != {AW{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == {AW{1'b0}}) ? {N{1'b0}} : regs_r[raddr_a];
  assign rdata_b = (raddr_b == {AW{1'b0}}) ? {N{1'b0}} : regs_r[raddr_b];

endmodule

// File: rtl/alu_driver.sv
// Issues one instruction at a time to the external ALU, holds DIV/MOD for a
// multicycle window, then writes the result back or issues an ALM store.
module alu_driver
  import alu_pkg::*;
#(
  parameter int N          = ALU_W,
  parameter int NREG       = 16,
  parameter int DIV_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_driver_if.master bus
);

  localparam int AW = $clog2(NREG);
  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  drv_state_t    state_r;
  drv_state_t    state_s;
  alu_op_t       op_r;
  alu_op_t       in_op_s;
  logic [AW-1:0] rd_r;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [CW-1:0] cnt_r;

  logic          wb_valid_r;
  logic [AW-1:0] wb_addr_r;
  logic [N-1:0]  wb_data_r;
  logic [2:0]    flags_r;
  logic          mem_we_r;
  logic [N-1:0]  mem_addr_r;
  logic [N-1:0]  mem_wdata_r;

  logic [N-1:0]  rdata_a_s;
  logic [N-1:0]  rdata_b_s;
  logic [N-1:0]  result_s;
  logic [2:0]    flags_s;
  logic          accept_s;
  logic          last_s;
  logic          div_zero_s;

  reg_file #(
    .N    (N),
    .NREG (NREG),
    .AW   (AW)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_valid_r),
    .waddr   (wb_addr_r),
    .wdata   (wb_data_r),
    .raddr_a (bus.in_ra),
    .raddr_b (bus.in_rb),
    .rdata_a (rdata_a_s),
    .rdata_b (rdata_b_s)
  );

  // Handshake/EXEC decode and divide-by-zero substitution of the ALU output.
  always_comb begin
    in_op_s    = alu_op_t'(bus.in_op);
    accept_s   = (state_r == IDLE) && bus.in_valid;
    last_s     = (state_r == EXEC) && (cnt_r == CNT_ZERO);
    div_zero_s = is_multicycle(op_r) && (b_r == {N{1'b0}});
    if (div_zero_s) begin
      result_s        = {N{1'b1}};
      flags_s         = 3'b000;
      flags_s[FLAG_O] = 1'b1;
      flags_s[FLAG_N] = 1'b1;
    end else begin
      result_s = bus.alu_result;
      flags_s  = bus.alu_flags;
    end
  end

  // Next-state logic for IDLE -> EXEC -> WB -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = EXEC;
        else          state_s = IDLE;
      end
      EXEC: begin
        if (last_s) state_s = WB;
        else        state_s = EXEC;
      end
      WB:      state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Operand latch, EXEC down-counter, and registered writeback/store outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= OP_SUM;
      rd_r        <= {AW{1'b0}};
      a_r         <= {N{1'b0}};
      b_r         <= {N{1'b0}};
      cnt_r       <= CNT_ZERO;
      wb_valid_r  <= 1'b0;
      wb_addr_r   <= {AW{1'b0}};
      wb_data_r   <= {N{1'b0}};
      flags_r     <= 3'b000;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {N{1'b0}};
      mem_wdata_r <= {N{1'b0}};
    end else begin
      if (accept_s) begin
        op_r  <= in_op_s;
        rd_r  <= bus.in_rd;
        a_r   <= rdata_a_s;
        b_r   <= bus.in_imm_en ? bus.in_imm : rdata_b_s;
        cnt_r <= is_multicycle(in_op_s) ? CNT_LOAD : CNT_ZERO;
      end else if ((state_r == EXEC) && (cnt_r != CNT_ZERO)) begin
        cnt_r <= cnt_r - CNT_ONE;
      end

      wb_valid_r <= 1'b0;
      mem_we_r   <= 1'b0;
      if (last_s) begin
        // ALM stores A at address B and leaves registers and status alone.
        if (op_r == OP_ALM) begin
          mem_we_r    <= 1'b1;
          mem_addr_r  <= b_r;
          mem_wdata_r <= a_r;
        end else begin
          wb_valid_r <= 1'b1;
          wb_addr_r  <= rd_r;
          wb_data_r  <= result_s;
          flags_r    <= flags_s;
        end
      end
    end
  end

  assign bus.in_ready  = rst_n && (state_r == IDLE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.alu_a     = a_r;
  assign bus.alu_b     = b_r;
  assign bus.alu_ctrl  = op_r;
  assign bus.wb_valid  = wb_valid_r;
  assign bus.wb_addr   = wb_addr_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.flags_q   = flags_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver: a behavioural ALU closes the loop, expected
// writebacks/stores are queued at issue and matched against monitored outputs.
module tb_alu_driver;
  import alu_pkg::*;

  localparam int N  = 19;
  localparam int DC = 3;

  typedef struct packed {
    logic         wb;
    logic         mem;
    logic [3:0]   addr;
    logic [N-1:0] data;
    logic [2:0]   flags;
    logic [N-1:0] maddr;
    logic [N-1:0] mdata;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  ev_t          sb[$];
  ev_t          obs_q[$];
  int           obs_c[$];
  logic [N-1:0] mregs [16];
  logic [2:0]   mflags;
  logic [N+2:0] alu_out;

  alu_driver_if #(.N(N), .AW(4)) bus ();

  alu_driver #(.N(N), .NREG(16), .DIV_CYCLES(DC)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: returns {Z,O,N,result}.
  function automatic logic [N+2:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    logic         o;
    o = 1'b0;
    case (op)
      3'b000: begin r = a + b; o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
      3'b001: begin r = a - b; o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
      3'b010: r = a * b;
      3'b011: r = (b == '0) ? '0 : a / b;
      3'b100: r = (b == '0) ? '0 : a % b;
      3'b101: r = ~a;
      3'b110: r = a;
      default: r = a + b;
    endcase
    return {(r == '0), o, r[N-1], r};
  endfunction

  // What the driver should report: divide-by-zero overrides the ALU.
  function automatic logic [N+2:0] expect_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    if ((op == 3'b011 || op == 3'b100) && b == '0) return {3'b011, {N{1'b1}}};
    return alu_fn(op, a, b);
  endfunction

  always_comb alu_out = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus.alu_result = alu_out[N-1:0];
  assign bus.alu_flags  = alu_out[N+2:N];

  function automatic ev_t sample_ev();
    ev_t m;
    m = '0;
    m.wb    = bus.wb_valid;
    m.mem   = bus.mem_we;
    m.flags = bus.flags_q;
    if (bus.wb_valid) begin m.addr = bus.wb_addr; m.data = bus.wb_data; end
    if (bus.mem_we) begin m.maddr = bus.mem_addr; m.mdata = bus.mem_wdata; end
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (bus.wb_valid || bus.mem_we)) begin
      obs_q.push_back(sample_ev());
      obs_c.push_back(cyc);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                       input logic imm_en, input logic [N-1:0] imm, input bit keep, output int hs);
    logic [N-1:0] a, b;
    logic [N+2:0] r;
    ev_t e;
    int n;
    n = 0;
    hs = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      compared++; mismatched++;
      $display("FAIL issue_timeout in_ready=%b required=1", bus.in_ready);
      return;
    end
    bus.in_op = op; bus.in_rd = rd; bus.in_ra = ra; bus.in_rb = rb;
    bus.in_imm_en = imm_en; bus.in_imm = imm; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    hs = cyc;
    if (!keep) bus.in_valid = 1'b0;
    a = (ra == 4'd0) ? '0 : mregs[ra];
    b = imm_en ? imm : ((rb == 4'd0) ? '0 : mregs[rb]);
    r = expect_fn(op, a, b);
    e = '0;
    if (op == 3'b111) begin
      e.mem = 1'b1; e.maddr = b; e.mdata = a; e.flags = mflags;
    end else begin
      e.wb = 1'b1; e.addr = rd; e.data = r[N-1:0]; e.flags = r[N+2:N];
      mflags = r[N+2:N];
      if (rd != 4'd0) mregs[rd] = r[N-1:0];
    end
    sb.push_back(e);
  endtask

  task automatic next_pair(output ev_t o, output ev_t e, output int c, output bit ok);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < 40) begin @(negedge clk); n++; end
    ok = (obs_q.size() != 0) && (sb.size() != 0);
    o = '0; e = '0; c = 0;
    if (obs_q.size() != 0) begin o = obs_q.pop_front(); c = obs_c.pop_front(); end
    if (sb.size() != 0) e = sb.pop_front();
  endtask

  task automatic load(input logic [3:0] rd, input logic [N-1:0] val);
    ev_t o, e;
    int hs, c;
    bit ok;
    issue(3'b000, rd, 4'd0, 4'd0, 1'b1, val, 1'b0, hs);
    next_pair(o, e, c, ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.in_ready, bus.busy, bus.wb_valid, bus.mem_we, bus.flags_q, bus.alu_ctrl} !== 10'b0 ||
        bus.alu_a !== '0 || bus.alu_b !== '0 || bus.wb_data !== '0 || bus.mem_addr !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs rdy=%b busy=%b wb=%b we=%b flags=%b ctrl=%b a=%h b=%h required all 0",
               bus.in_ready, bus.busy, bus.wb_valid, bus.mem_we, bus.flags_q, bus.alu_ctrl, bus.alu_a, bus.alu_b);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_sum_back_to_back();
    ev_t o, e;
    int hs0, hs1, c0, c1;
    bit ok;
    load(4'd1, 19'd5);
    load(4'd2, 19'd7);
    issue(3'b000, 4'd3, 4'd1, 4'd2, 1'b0, '0, 1'b0, hs0);
    issue(3'b000, 4'd7, 4'd3, 4'd0, 1'b0, '0, 1'b0, hs1);
    compared++;
    if (hs1 - hs0 != 3) begin mismatched++; $display("FAIL b2b_spacing got=%0d required=3", hs1 - hs0); end
    next_pair(o, e, c0, ok);
    compared++;
    if (!ok || o !== e) begin mismatched++; $display("FAIL sum_r3 got=%h required=%h", o, e); end
    compared++;
    if (o.data !== 19'd12 || o.flags !== 3'b000) begin
      mismatched++; $display("FAIL sum_value data=%0d flags=%b required 12/000", o.data, o.flags);
    end
    compared++;
    if (c0 - hs0 != 1) begin mismatched++; $display("FAIL sum_latency got=%0d required=1", c0 - hs0); end
    next_pair(o, e, c1, ok);
    compared++;
    if (!ok || o !== e) begin mismatched++; $display("FAIL sum_readback_r3 got=%h required=%h", o, e); end
    compared++;
    if (c1 - c0 != 3) begin mismatched++; $display("FAIL wb_pulse_spacing got=%0d required=3", c1 - c0); end
  endtask

  task automatic test_res();
    ev_t o, e;
    int hs, c;
    bit ok;
    issue(3'b001, 4'd4, 4'd1, 4'd0, 1'b1, 19'd5, 1'b0, hs);
    next_pair(o, e, c, ok);
    compared++;
    if (!ok || o !== e || o.data !== '0 || o.flags !== 3'b100) begin
      mismatched++; $display("FAIL res_zero got=%h required=%h", o, e);
    end
    issue(3'b001, 4'd4, 4'd0, 4'd0, 1'b1, 19'd1, 1'b0, hs);
    next_pair(o, e, c, ok);
    compared++;
    if (!ok || o !== e || o.data !== 19'h7FFFF || o.flags !== 3'b001) begin
      mismatched++; $display("FAIL res_neg got=%h required=%h", o, e);
    end
  endtask

  task automatic test_div_mod();
    ev_t o, e;
    int hs, c;
    bit ok;
    load(4'd1, 19'd100);
    load(4'd2, 19'd7);
    issue(3'b011, 4'd6, 4'd1, 4'd2, 1'b0, '0, 1'b0, hs);
    for (int k = 0; k < DC; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.wb_valid} !== {19'd100, 19'd7, 3'b011, 1'b0}) begin
        mismatched++;
        $display("FAIL div_hold_%0d a=%0d b=%0d ctrl=%b wb=%b required 100/7/011/0",
                 k, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.wb_valid);
      end
    end
    next_pair(o, e, c, ok);
    compared++;
    if (!ok || o !== e || o.data !== 19'd14) begin mismatched++; $display("FAIL div got=%h required=%h", o, e); end
    compared++;
    if (c - hs != DC) begin mismatched++; $display("FAIL div_latency got=%0d required=%0d", c - hs, DC); end
    issue(3'b100, 4'd6, 4'd1, 4'd2, 1'b0, '0, 1'b0, hs);
    next_pair(o, e, c, ok);
    compared++;
    if (!ok || o !== e || o.data !== 19'd2) begin mismatched++; $display("FAIL mod got=%h required=%h", o, e); end
  endtask

  task automatic test_div_zero_alm();
    ev_t o, e;
    int hs, c;
    bit ok;
    load(4'd11, 19'h01234);
    issue(3'b011, 4'd6, 4'd1, 4'd0, 1'b0, '0, 1'b0, hs);
    next_pair(o, e, c, ok);
    compared++;
    if (!ok || o !== e || o.data !== 19'h7FFFF || o.flags !== 3'b011) begin
      mismatched++; $display("FAIL div_zero got=%h required=%h", o, e);
    end
    issue(3'b111, 4'd5, 4'd11, 4'd0, 1'b1, 19'h10, 1'b0, hs);
    next_pair(o, e, c, ok);
    compared++;
    if (!ok || o !== e) begin mismatched++; $display("FAIL alm got=%h required=%h", o, e); end
    compared++;
    if (o.wb !== 1'b0 || o.mem !== 1'b1 || o.maddr !== 19'h10 || o.mdata !== 19'h01234 || o.flags !== 3'b011) begin
      mismatched++;
      $display("FAIL alm_fields wb=%b we=%b addr=%h wdata=%h flags=%b required 0/1/10/1234/011",
               o.wb, o.mem, o.maddr, o.mdata, o.flags);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (obs_q.size() != 0) begin mismatched++; $display("FAIL alm_single_pulse extra=%0d required=0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_div();
    ev_t o, e;
    int hs, c;
    bit ok;
    issue(3'b011, 4'd5, 4'd1, 4'd2, 1'b0, '0, 1'b0, hs);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.busy, bus.wb_valid, bus.mem_we, bus.flags_q, bus.in_ready} !== 7'b0) begin
      mismatched++;
      $display("FAIL abort_state busy=%b wb=%b we=%b flags=%b rdy=%b required all 0",
               bus.busy, bus.wb_valid, bus.mem_we, bus.flags_q, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL abort_ready got=%b required=1", bus.in_ready); end
    e = sb.pop_back();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflags = 3'b000;
    repeat (6) @(negedge clk);
    compared++;
    if (obs_q.size() != 0) begin mismatched++; $display("FAIL abort_no_wb got=%0d required=0", obs_q.size()); end
    issue(3'b000, 4'd7, 4'd5, 4'd0, 1'b0, '0, 1'b0, hs);
    next_pair(o, e, c, ok);
    compared++;
    if (!ok || o !== e || o.data !== '0) begin mismatched++; $display("FAIL abort_r5 got=%h required=%h", o, e); end
  endtask

  task automatic test_stream();
    ev_t o, e;
    int h[4];
    int c;
    bit ok;
    load(4'd1, 19'd13);
    load(4'd2, 19'd9);
    issue(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 19'd9, 1'b1, h[0]);
    issue(3'b000, 4'd8, 4'd0, 4'd0, 1'b0, '0, 1'b1, h[1]);
    issue(3'b010, 4'd9, 4'd1, 4'd2, 1'b0, '0, 1'b1, h[2]);
    issue(3'b110, 4'd10, 4'd1, 4'd0, 1'b0, '0, 1'b1, h[3]);
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      compared++;
      if (h[i] - h[i-1] != 3) begin mismatched++; $display("FAIL stream_spacing_%0d got=%0d required=3", i, h[i] - h[i-1]); end
    end
    for (int i = 0; i < 4; i++) begin
      next_pair(o, e, c, ok);
      compared++;
      if (!ok || o !== e) begin mismatched++; $display("FAIL stream_op_%0d got=%h required=%h", i, o, e); end
    end
  endtask

  task automatic test_drain();
    repeat (8) @(negedge clk);
    compared++;
    if (sb.size() != 0 || obs_q.size() != 0) begin
      mismatched++; $display("FAIL leftovers expected=%0d observed=%0d required 0/0", sb.size(), obs_q.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 3'b000; bus.in_rd = 4'd0; bus.in_ra = 4'd0; bus.in_rb = 4'd0;
    bus.in_imm_en = 1'b0; bus.in_imm = '0;
    mflags = 3'b000;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    test_reset();
    test_sum_back_to_back();
    test_res();
    test_div_mod();
    test_div_zero_alm();
    test_reset_mid_div();
    test_stream();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Sequencing front end that issues one instruction at a time to the 19-bit ALU and consumes its `Result` and `ALUFlags`. It owns a 16-entry register file, reads the operands, and drives the ALU's `A`, `B` and `ALUControl` inputs. It holds DIV/MOD for a multicycle window, then writes the result back and latches the Z/O/N status. It sits between the instruction decode stage and the ALU, and also issues ALM stores to data memory.

## Interface
Parameters:
- `N`, 19: datapath width; matches the ALU.
- `NREG`, 16: register count; address width is `$clog2(NREG)`.
- `DIV_CYCLES`, 3: EXEC cycles held for DIV/MOD (multicycle path through the combinational divider); minimum 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: driver can accept.
- `in_op` in 3: 000 SUM, 001 RES, 010 MULT, 011 DIV, 100 MOD, 101 CLI, 110 TRFI, 111 ALM.
- `in_rd`, `in_ra`, `in_rb` in 4: destination and source registers.
- `in_imm_en` in 1: replace B with `in_imm`.
- `in_imm` in N: immediate operand.
- `alu_a`, `alu_b` out N: ALU operands.
- `alu_ctrl` out 3: ALU opcode.
- `alu_result` in N: ALU `Result`.
- `alu_flags` in 3: ALU flags, ordered {Z,O,N}.
- `wb_valid` out 1: writeback pulse.
- `wb_addr` out 4, `wb_data` out N: writeback target and value.
- `flags_q` out 3: registered status, {Z,O,N}.
- `mem_we` out 1, `mem_addr` out N, `mem_wdata` out N: ALM store.
- `busy` out 1: not in IDLE.

## Operation
States:
- IDLE: `in_ready`=1.
  - On `in_valid`: latch op and rd, read ra/rb (B = `in_imm` if `in_imm_en`), go to EXEC.
- EXEC: operand/op registers drive `alu_a`, `alu_b`, `alu_ctrl`.
  - DIV/MOD stay `DIV_CYCLES` cycles, counted by a down-counter; other ops stay 1 cycle.
  - On the last cycle: capture `alu_result`/`alu_flags`, go to WB.
- WB: one cycle, then IDLE.
  - Ops 000–110: `wb_valid`=1, `wb_addr`=rd, `wb_data`=captured result.
  - Register file is written at the end of WB.
  - `flags_q` is updated at WB entry.

Rules:
- r0 reads 0; writes to r0 assert `wb_valid` but are discarded.
- ALM (111): no register write; `flags_q` unchanged; `mem_we`=1 in WB, with `mem_addr`=B and `mem_wdata`=A.
- DIV/MOD with B==0: ALU output is ignored.
  - Result = {N{1'b1}}.
  - Flags = {0,1,1} (O set to flag the error).
- Outputs not being used hold their last value; `alu_ctrl` holds the last op.
- Reset (any state, including mid-EXEC): return to IDLE, abort with no writeback and no `mem_we`.
  - Reset values: registers 0, `flags_q`=0, all outputs 0, `in_ready`=1 once `rst_n` is high.

## Timing
- Handshake completes at rising edge E0 (`in_valid` & `in_ready`).
- EXEC occupies E0–E1; DIV/MOD occupy E0–E(`DIV_CYCLES`).
- `wb_valid` is high for exactly one cycle:
  - E1–E2 for single-cycle ops.
  - E(`DIV_CYCLES`)–E(`DIV_CYCLES`+1) for DIV/MOD.
- Register is written at E2 (E(`DIV_CYCLES`+1) for DIV/MOD); `in_ready` rises in the same cycle.
- Next handshake no earlier than the following edge, so there is no read-after-write hazard and no bypass.
- Throughput: 3 cycles/op; DIV/MOD `DIV_CYCLES`+2.
- `alu_a`, `alu_b`, `alu_ctrl` are stable for the whole EXEC window.
- `in_valid` while `in_ready`=0 is ignored; there is no buffering.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum with OP_SUM…OP_ALM (3-bit encodings above).
  - Flag index constants FLAG_Z=2, FLAG_O=1, FLAG_N=0.
  - `drv_state_t` enum {IDLE, EXEC, WB}.
  - Constant ALU_W=19.
- Sub-module `reg_file`: NREG×N, two asynchronous read ports, one synchronous write port, r0 hardwired zero, cleared on `rst_n`.
- The ALU is instantiated by the parent, not inside `alu_driver`.

## Test plan
- Reset mid-DIV (assert `rst_n`=0 during EXEC cycle 2) → no `wb_valid`, `flags_q`=000, `in_ready`=1 after release, r5 unchanged.
- SUM r3 ← r1 + r2 with r1=5, r2=7 → `wb_valid` one cycle at E1, `wb_data`=12, `flags_q`=000, r3=12 at E2; back-to-back issue accepted at E3.
- RES r4 ← r1 − imm 5 with r1=5 → result 0, `flags_q`=100; then RES r4 ← r0 − imm 1 → 19'h7FFFF, `flags_q`=001.
- DIV r6 ← r1 / r2 with r1=100, r2=7, `DIV_CYCLES`=3 → `alu_*` stable 3 cycles, `wb_data`=14; MOD with the same operands → 2.
- DIV by r0 → `wb_data`=19'h7FFFF, `flags_q`=011; ALM with A=0x1234, B=0x10 → `mem_we` one cycle, `mem_addr`=0x10, `mem_wdata`=0x1234, `flags_q` unchanged, no `wb_valid`.
- `in_valid` held high throughout a stream of 4 ops → exactly 4 handshakes at 3-cycle spacing; write to r0 leaves r0 reading 0.
